// File: rtl/btc_pkg.sv
// btc_pkg: shared state encoding, digest size and byte-index width for the host driver and miner top.
package btc_pkg;
  localparam int HASH_BYTES = 32;
  localparam int IDX_W = $clog2(HASH_BYTES) + 1;
  typedef enum logic [1:0] {IDLE, START, FEED, COLLECT} btc_state_e;
  function automatic int hash_lsb(input logic [IDX_W-1:0] k);
    return 8 * (HASH_BYTES - 1 - int'(k));
  endfunction
endpackage

// File: rtl/btc_host_hs.sv
// btc_host_hs: four-phase rdy/rq handshake engine; offer raises rdy, cap marks the first rq&rdy edge, release drops rdy.
module btc_host_hs (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic rq_i,
  input  logic ok_i,
  output logic rdy_o,
  output logic offer_o,
  output logic cap_o,
  output logic rel_o
);
  logic rdy_q, taken_q;
  assign rdy_o   = rdy_q;
  assign offer_o = rq_i & ~rdy_q & ok_i;
  assign cap_o   = rq_i & rdy_q & ~taken_q;
  assign rel_o   = rdy_q & ~rq_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdy_q   <= 1'b0;
      taken_q <= 1'b0;
    end else if (clr_i) begin
      rdy_q   <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      rdy_q   <= offer_o | (rdy_q & rq_i);
      taken_q <= rdy_q & rq_i;
    end
endmodule

// File: rtl/btc_host_driver.sv
// btc_host_driver: feeds upstream bytes to the miner and collects the 32-byte digest over rq/rdy.
// Optional watchdog abort enabled by defining BTC_HOST_TIMEOUT_EN.
module btc_host_driver
  import btc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int FEED_CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  go,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  dut_start,
  output logic                  dut_rdy,
  output logic [7:0]            dut_data,
  input  logic                  dut_rq,
  input  logic                  dut_done,
  input  logic [7:0]            dut_hash,
  output logic [255:0]          hash,
  output logic                  hash_valid,
  output logic                  busy,
  output logic                  err,
  output logic [FEED_CNT_W-1:0] bytes_fed
);
  btc_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [7:0] data_q;
  logic [255:0] hash_q;
  logic [FEED_CNT_W-1:0] fed_q;
  logic done_q, in_ready_q, hash_valid_q, err_q;
  logic feed, coll, done_any, ok, offer, cap, rel, last, abort;
  assign feed     = state_q == FEED;
  assign coll     = state_q == COLLECT;
  assign done_any = dut_done | done_q;
  // once done is seen no further byte is offered; COLLECT stops offering after the last digest byte
  assign ok       = ~abort & (feed ? in_valid & ~done_any : coll & (idx_q != IDX_W'(HASH_BYTES)));
  assign last     = coll & rel & (idx_q == IDX_W'(HASH_BYTES));
  btc_host_hs u_hs (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (abort | ~(feed | coll)),
    .rq_i   (dut_rq),
    .ok_i   (ok),
    .rdy_o  (dut_rdy),
    .offer_o(offer),
    .cap_o  (cap),
    .rel_o  (rel)
  );
`ifdef BTC_HOST_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;
  logic rq_q, dn_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wd_q <= '0;
      rq_q <= 1'b0;
      dn_q <= 1'b0;
    end else begin
      rq_q <= dut_rq;
      dn_q <= dut_done;
      wd_q <= (~(feed | coll) | (dut_rq ^ rq_q) | (dut_done & ~dn_q)) ? '0 : wd_q + 1'b1;
    end
  assign abort = (feed | coll) & (wd_q == WD_W'(TIMEOUT_CYCLES));
`else
  assign abort = 1'b0;
`endif
  always_comb
    state_d = abort ? IDLE :
              state_q == IDLE  ? (go ? START : IDLE) :
              state_q == START ? FEED :
              feed ? (done_any & ~dut_rdy ? COLLECT : FEED) :
              (hash_valid_q ? IDLE : COLLECT);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      data_q       <= '0;
      hash_q       <= '0;
      fed_q        <= '0;
      done_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      hash_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      done_q       <= feed & done_any;
      in_ready_q   <= feed & offer;
      hash_valid_q <= last;
      err_q        <= abort;
      if (state_q == IDLE && go) begin
        fed_q <= '0;
        idx_q <= '0;
      end
      if (feed & offer) begin
        data_q <= in_data;
        fed_q  <= fed_q + FEED_CNT_W'(fed_q != '1);
      end
      if (coll & cap) begin
        hash_q[hash_lsb(idx_q) +: 8] <= dut_hash;
        idx_q                        <= idx_q + 1'b1;
      end
    end
  assign in_ready   = in_ready_q;
  assign dut_start  = state_q == START;
  assign dut_data   = data_q;
  assign hash       = hash_q;
  assign hash_valid = hash_valid_q;
  assign busy       = state_q != IDLE;
  assign err        = err_q;
  assign bytes_fed  = fed_q;
endmodule

// File: doc/btc_host_driver.md
BTC_HOST_DRIVER -- requirements
Module: btc_host_driver

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 65535, maximum cycles without handshake progress before abort (used only with BTC_HOST_TIMEOUT_EN).
REQ-002 Parameter FEED_CNT_W, default 16, width of fed-byte counter.
REQ-003 clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-004 go  in  1  one-cycle request to run one hash job; ignored unless idle.
REQ-005 in_data  in  8  upstream message byte; in_valid  in  1  byte available; in_ready  out  1  one-cycle consume strobe.
REQ-006 dut_start  out  1; dut_rdy  out  1; dut_data  out  8  (drive miner uio_in[0], uio_in[1], ui_in).
REQ-007 dut_rq  in  1; dut_done  in  1; dut_hash  in  8  (from miner uio_out[2], uio_out[3], uo_out); same clk domain.
REQ-008 hash  out  256  collected digest; hash_valid  out  1  one-cycle strobe; busy  out  1; err  out  1  one-cycle abort strobe.
REQ-009 bytes_fed  out  FEED_CNT_W  bytes delivered in current/last job, saturating.

Function
REQ-010 States IDLE, START, FEED, COLLECT; busy=1 in every state except IDLE.
REQ-011 IDLE: go=1 -> START, clear bytes_fed and byte index.
REQ-012 START: dut_start=1 for exactly one cycle, then FEED unconditionally.
REQ-013 FEED byte handshake: when dut_rq=1, dut_rdy=0, in_valid=1 -> next cycle dut_data<=in_data, dut_rdy<=1, in_ready pulses one cycle, bytes_fed++.
REQ-014 dut_rdy, once set, holds with dut_data stable until dut_rq observed 0, then clears next cycle (four-phase); no new byte offered while dut_rdy=1.
REQ-015 dut_rq=1 with in_valid=0: wait, dut_rdy stays 0, no timeout exemption.
REQ-016 FEED: dut_done=1 -> COLLECT; an in-flight dut_rdy completes its four-phase release first.
REQ-017 COLLECT: dut_rq=1 and dut_rdy=0 -> dut_rdy<=1; on the edge where dut_rq=1 and dut_rdy=1, capture dut_hash into hash[255-8*k -: 8], k=byte index 0..31, MSB byte first.
REQ-018 COLLECT release identical to REQ-014; after capture of k=31, hash_valid pulses on the cycle after dut_rdy clears, state -> IDLE.
REQ-019 hash holds last completed digest until next capture overwrites; partial overwrite during a job permitted.
REQ-020 go during busy ignored; bytes_fed saturates at all-ones.

Reset
REQ-021 Reset (any time, including mid-handshake): state IDLE, dut_start=0, dut_rdy=0, dut_data=0, in_ready=0, hash=0, hash_valid=0, err=0, busy=0, bytes_fed=0, index=0.

Configuration
REQ-022 Macro BTC_HOST_TIMEOUT_EN defined: watchdog counter resets on every dut_rq edge or dut_done rise; reaching TIMEOUT_CYCLES in FEED/COLLECT -> err pulse, dut_rdy=0, state IDLE, hash_valid not pulsed.
REQ-023 Macro undefined: no watchdog logic, err tied 0, driver waits indefinitely.

Structure
REQ-024 Shared package btc_pkg holds state enum, HASH_BYTES=32, byte-index width; miner top reuses HASH_BYTES.
REQ-025 One sub-module btc_host_hs: four-phase rdy/rq handshake engine (offer, capture strobe, release) shared by FEED and COLLECT.

Verification
REQ-026 go with 80 upstream bytes 0x00..0x4F, behavioural miner requesting 80 bytes then done -> bytes_fed=80, miner receives exact sequence, each byte once.
REQ-027 COLLECT with miner presenting 0x00..0x1F -> hash=0x000102...1F, hash_valid one cycle, busy=0 next cycle.
REQ-028 in_valid held 0 for 50 cycles while dut_rq=1 -> dut_rdy stays 0, no byte lost, resumes correctly.
REQ-029 rst_n low while dut_rdy=1 in FEED -> all outputs per REQ-021 same cycle; subsequent go runs cleanly.
REQ-030 BTC_HOST_TIMEOUT_EN, TIMEOUT_CYCLES=100, miner stalls rq low after 10 bytes -> err pulse at cycle 100, busy=0, no hash_valid.
REQ-031 go pulsed twice during busy -> ignored; single job, single hash_valid.
